// File: rtl/condicionador_entradas.sv
`default_nettype none
// ============================================================================
// Module      : condicionador_entradas
// Description : Input-conditioning stage in front of the game datapath and
//               control unit. Synchronises and debounces the raw start
//               button and the raw switch vector, producing:
//                 - a one-cycle start pulse (feeds the control unit iniciar);
//                 - a latched switch pattern (feeds the datapath chaves) with
//                   a one-cycle strobe whenever that pattern is updated.
//               Each press yields exactly one accepted pattern; a new one is
//               only taken after every switch has been released.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles required (>= 2).
//                     4 for simulation, 50000 (1 ms @ 50 MHz) on the board.
//   N_CHAVES        : switch vector width.
// Ports
//   clock         in   1         system clock, rising edge
//   reset         in   1         asynchronous reset, active high
//   iniciar_raw   in   1         raw start button, asynchronous to clock
//   chaves_raw    in   N_CHAVES  raw switches, asynchronous to clock
//   iniciar_pulso out  1         one-cycle pulse on debounced start press
//   jogada        out  N_CHAVES  last accepted pattern, held until next accept
//   jogada_pulso  out  1         one-cycle pulse while jogada shows a new value
//   erro_jogada   out  1         one-cycle pulse on a rejected (non one-hot)
//                                pattern; constant 0 unless ONEHOT_CHECK_EN
//   db_estado     out  4         switch FSM state code for the 7-seg debug
// Build options
//   ONEHOT_CHECK_EN : when defined, a stable pattern that is not one-hot is
//                     rejected (erro_jogada pulse, jogada untouched) instead
//                     of being accepted.
// ============================================================================
module condicionador_entradas #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int N_CHAVES        = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar_raw,
  input  logic [N_CHAVES-1:0] chaves_raw,
  output logic                iniciar_pulso,
  output logic [N_CHAVES-1:0] jogada,
  output logic                jogada_pulso,
  output logic                erro_jogada,
  output logic [3:0]          db_estado
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 bits suffice and
  // it never needs to wrap.
  localparam int             CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,  // waiting for any switch
    FILTRA   = 2'd1,  // candidate pattern must stay stable for the window
    REGISTRA = 2'd2,  // single cycle: pattern accepted, strobe high
    SOLTA    = 2'd3   // waiting for all switches released for the window
  } estado_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronisers
  // --------------------------------------------------------------------------
  logic [N_CHAVES-1:0] chaves_meta_d, chaves_meta_q;
  logic [N_CHAVES-1:0] chaves_sync_d, chaves_sync_q;
  logic                iniciar_meta_d, iniciar_meta_q;
  logic                iniciar_sync_d, iniciar_sync_q;

  always_comb begin
    chaves_meta_d  = chaves_raw;
    chaves_sync_d  = chaves_meta_q;
    iniciar_meta_d = iniciar_raw;
    iniciar_sync_d = iniciar_meta_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chaves_meta_q  <= '0;
      chaves_sync_q  <= '0;
      iniciar_meta_q <= 1'b0;
      iniciar_sync_q <= 1'b0;
    end else begin
      chaves_meta_q  <= chaves_meta_d;
      chaves_sync_q  <= chaves_sync_d;
      iniciar_meta_q <= iniciar_meta_d;
      iniciar_sync_q <= iniciar_sync_d;
    end
  end

  // --------------------------------------------------------------------------
  // Switch channel: Moore FSM with a shared window counter
  // --------------------------------------------------------------------------
  estado_t             estado_d, estado_q;
  logic [N_CHAVES-1:0] cand_d, cand_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic [N_CHAVES-1:0] jogada_d, jogada_q;
`ifdef ONEHOT_CHECK_EN
  logic                erro_d, erro_q;
`endif

  always_comb begin
    estado_d = estado_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    jogada_d = jogada_q;
`ifdef ONEHOT_CHECK_EN
    erro_d   = 1'b0;
`endif
    case (estado_q)
      ESPERA: begin
        if (chaves_sync_q != '0) begin
          estado_d = FILTRA;
          cand_d   = chaves_sync_q;
          cnt_d    = '0;
        end
      end

      FILTRA: begin
        if (chaves_sync_q == '0) begin
          estado_d = ESPERA;
          cnt_d    = '0;
        end else if (chaves_sync_q != cand_q) begin
          // Bounce or a second switch joining: restart the window on the
          // new pattern.
          cand_d = chaves_sync_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
`ifdef ONEHOT_CHECK_EN
          if ($onehot(cand_q)) begin
            estado_d = REGISTRA;
            jogada_d = cand_q;
          end else begin
            estado_d = SOLTA;
            erro_d   = 1'b1;
          end
`else
          estado_d = REGISTRA;
          jogada_d = cand_q;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // jogada is loaded on entry so that the new value is already visible
      // during the single strobe cycle.
      REGISTRA: begin
        estado_d = SOLTA;
        cnt_d    = '0;
      end

      SOLTA: begin
        if (chaves_sync_q != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          estado_d = ESPERA;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        estado_d = ESPERA;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= ESPERA;
      cand_q   <= '0;
      cnt_q    <= '0;
      jogada_q <= '0;
`ifdef ONEHOT_CHECK_EN
      erro_q   <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      jogada_q <= jogada_d;
`ifdef ONEHOT_CHECK_EN
      erro_q   <= erro_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Start channel: independent filter on the synchronised button
  // --------------------------------------------------------------------------
  logic             iniciar_estavel_d, iniciar_estavel_q;
  logic [CNT_W-1:0] ini_cnt_d, ini_cnt_q;
  logic             ini_pulso_d, ini_pulso_q;

  // The stable level only follows the button after it has disagreed for the
  // full window; any agreeing cycle throws the partial count away.
  always_comb begin
    iniciar_estavel_d = iniciar_estavel_q;
    ini_cnt_d         = '0;
    ini_pulso_d       = 1'b0;
    if (iniciar_sync_q != iniciar_estavel_q) begin
      if (ini_cnt_q == CNT_LAST) begin
        iniciar_estavel_d = iniciar_sync_q;
        // Pulse only on the 0->1 flip; holding the button gives no more.
        ini_pulso_d       = iniciar_sync_q;
      end else begin
        ini_cnt_d = ini_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iniciar_estavel_q <= 1'b0;
      ini_cnt_q         <= '0;
      ini_pulso_q       <= 1'b0;
    end else begin
      iniciar_estavel_q <= iniciar_estavel_d;
      ini_cnt_q         <= ini_cnt_d;
      ini_pulso_q       <= ini_pulso_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign iniciar_pulso = ini_pulso_q;
  assign jogada        = jogada_q;
  assign jogada_pulso  = (estado_q == REGISTRA);
  assign db_estado     = {2'b00, estado_q};
`ifdef ONEHOT_CHECK_EN
  assign erro_jogada   = erro_q;
`else
  assign erro_jogada   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_condicionador_entradas.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_condicionador_entradas
// Description : Directed, self-checking bench for condicionador_entradas with
//               DEBOUNCE_CYCLES = 4. A run-length reference model predicts
//               every output each cycle; directed literals pin key timings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_condicionador_entradas;

  localparam int D = 4;
  localparam int N = 4;
`ifdef ONEHOT_CHECK_EN
  localparam bit ONEHOT = 1'b1;
`else
  localparam bit ONEHOT = 1'b0;
`endif

  localparam int ARMADO  = 0;  // switches may be pressed and filtered
  localparam int ACEITO  = 1;  // pattern taken this cycle
  localparam int TRAVADO = 2;  // waiting for full release

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         iniciar_raw = 1'b0;
  logic [N-1:0] chaves_raw = '0;
  logic         iniciar_pulso;
  logic [N-1:0] jogada;
  logic         jogada_pulso;
  logic         erro_jogada;
  logic [3:0]   db_estado;

  condicionador_entradas #(
    .DEBOUNCE_CYCLES(D),
    .N_CHAVES       (N)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar_raw  (iniciar_raw),
    .chaves_raw   (chaves_raw),
    .iniciar_pulso(iniciar_pulso),
    .jogada       (jogada),
    .jogada_pulso (jogada_pulso),
    .erro_jogada  (erro_jogada),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: raw inputs delayed two edges, then judged by run lengths
  // --------------------------------------------------------------------------
  logic [N-1:0] m_d1, m_d2, m_last, m_jog;
  logic         mi_d1, mi_d2, m_stable;
  int           m_mode, same_len, zero_len, diff_len;
  logic         m_pulse, m_err, m_ini_pulse;
  logic [3:0]   m_code;
  int           cnt_jp = 0, cnt_ip = 0, cnt_err = 0;

  initial begin : model_and_compare
    logic [N-1:0] s;
    logic         si;
    forever begin
      @(posedge clock);
      if (reset) begin
        m_d1 = '0; m_d2 = '0; m_last = '0; m_jog = '0;
        mi_d1 = 1'b0; mi_d2 = 1'b0; m_stable = 1'b0;
        m_mode = ARMADO; same_len = 0; zero_len = 0; diff_len = 0;
        m_pulse = 1'b0; m_err = 1'b0; m_ini_pulse = 1'b0;
      end else begin
        s  = m_d2;
        si = mi_d2;
        m_d2 = m_d1; m_d1 = chaves_raw;
        mi_d2 = mi_d1; mi_d1 = iniciar_raw;
        m_pulse = 1'b0; m_err = 1'b0; m_ini_pulse = 1'b0;

        if (m_mode == ACEITO) begin
          m_mode   = TRAVADO;
          zero_len = 0;
        end else if (m_mode == TRAVADO) begin
          zero_len = (s == '0) ? zero_len + 1 : 0;
          if (zero_len == D) begin
            m_mode   = ARMADO;
            same_len = 0;
          end
        end else begin
          if (s == '0) begin
            same_len = 0;
          end else begin
            same_len = (same_len > 0 && s == m_last) ? same_len + 1 : 1;
            m_last   = s;
          end
          // First sighting plus D confirming sightings of the same value.
          if (same_len == D + 1) begin
            if (!ONEHOT || $countones(s) == 1) begin
              m_mode  = ACEITO;
              m_jog   = s;
              m_pulse = 1'b1;
            end else begin
              m_mode   = TRAVADO;
              zero_len = 0;
              m_err    = 1'b1;
            end
          end
        end

        if (si != m_stable) begin
          diff_len++;
          if (diff_len == D) begin
            m_stable    = si;
            diff_len    = 0;
            m_ini_pulse = si;
          end
        end else begin
          diff_len = 0;
        end
      end
      m_code = (m_mode == ACEITO) ? 4'd2 : (m_mode == TRAVADO) ? 4'd3 :
               (same_len > 0) ? 4'd1 : 4'd0;

      #1;
      check("cmp_iniciar_pulso", iniciar_pulso, m_ini_pulse);
      check("cmp_jogada",        jogada,        m_jog);
      check("cmp_jogada_pulso",  jogada_pulso,  m_pulse);
      check("cmp_erro_jogada",   erro_jogada,   m_err);
      check("cmp_db_estado",     db_estado,     m_code);
      cnt_jp  += int'(jogada_pulso);
      cnt_ip  += int'(iniciar_pulso);
      cnt_err += int'(erro_jogada);
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus (inputs change on falling edges)
  // --------------------------------------------------------------------------
  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Waits for n rising edges and lands just after the last one.
  task automatic apos_bordas(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin : stimulus
    int n0, n1, n2, n3, n4, n5, n6, n7;

    // Power-on reset
    ciclos(3);
    check("rst_jogada", jogada, 4'b0000);
    check("rst_pulsos", {iniciar_pulso, jogada_pulso, erro_jogada}, 3'b000);
    check("rst_db", db_estado, 4'd0);
    reset = 1'b0;
    ciclos(4);

    // Clean press of 0100: edge 0 is the first rising edge after the change
    chaves_raw = 4'b0100;
    apos_bordas(2);
    check("clean_db_e1", db_estado, 4'd0);
    apos_bordas(1);
    check("clean_db_e2", db_estado, 4'd1);
    apos_bordas(3);
    check("clean_pulse_e5", jogada_pulso, 1'b0);
    apos_bordas(1);
    check("clean_pulse_e6", jogada_pulso, 1'b1);
    check("clean_jogada_e6", jogada, 4'b0100);
    check("clean_db_e6", db_estado, 4'd2);
    apos_bordas(1);
    check("clean_db_e7", db_estado, 4'd3);
    check("clean_pulse_e7", jogada_pulso, 1'b0);
    @(negedge clock);
    n0 = cnt_jp;

    // Held, then changed without release: must stay locked
    ciclos(20);
    chaves_raw = 4'b0010;
    ciclos(10);
    check("gate_no_second", n0 - cnt_jp, 0);
    check("gate_jogada_kept", jogada, 4'b0100);

    // Release, then press 0010
    chaves_raw = 4'b0000;
    ciclos(6);
    chaves_raw = 4'b0010;
    ciclos(10);
    check("gate_second_pulse", cnt_jp - n0, 1);
    check("gate_jogada_new", jogada, 4'b0010);

    // Asynchronous reset in the middle of a filter window
    chaves_raw = 4'b0000;
    ciclos(8);
    chaves_raw = 4'b0001;
    apos_bordas(4);
    check("mid_db_filtra", db_estado, 4'd1);
    #2 reset = 1'b1;
    chaves_raw = 4'b0000;
    #1;
    check("async_jogada", jogada, 4'b0000);
    check("async_db", db_estado, 4'd0);
    check("async_pulsos", {iniciar_pulso, jogada_pulso, erro_jogada}, 3'b000);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    n1 = cnt_jp;
    ciclos(15);
    check("rst_no_pulse_after", cnt_jp - n1, 0);

    // Bounce: three short bursts, then settle on 0100
    n2 = cnt_jp;
    for (int i = 0; i < 6; i++) begin
      chaves_raw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      ciclos(2);
    end
    check("bounce_no_pulse", cnt_jp - n2, 0);
    chaves_raw = 4'b0100;
    apos_bordas(6);
    check("bounce_pulse_e5", jogada_pulso, 1'b0);
    apos_bordas(1);
    check("bounce_pulse_e6", jogada_pulso, 1'b1);
    check("bounce_jogada", jogada, 4'b0100);
    ciclos(10);
    check("bounce_one_pulse", cnt_jp - n2, 1);
    chaves_raw = 4'b0000;
    ciclos(8);

    // Start held 30 cycles: one pulse, just after edge 5
    n3 = cnt_ip;
    iniciar_raw = 1'b1;
    apos_bordas(5);
    check("start_pulse_e4", iniciar_pulso, 1'b0);
    apos_bordas(1);
    check("start_pulse_e5", iniciar_pulso, 1'b1);
    @(negedge clock);
    ciclos(24);
    iniciar_raw = 1'b0;
    ciclos(10);
    check("start_one_pulse", cnt_ip - n3, 1);

    // Two-cycle glitch on the button
    n4 = cnt_ip;
    iniciar_raw = 1'b1;
    ciclos(2);
    iniciar_raw = 1'b0;
    ciclos(12);
    check("glitch_no_pulse", cnt_ip - n4, 0);

    // Simultaneous start and switch press
    n5 = cnt_jp;
    n6 = cnt_ip;
    iniciar_raw = 1'b1;
    chaves_raw  = 4'b0001;
    ciclos(12);
    check("simul_jogada_pulse", cnt_jp - n5, 1);
    check("simul_start_pulse", cnt_ip - n6, 1);
    check("simul_jogada", jogada, 4'b0001);
    iniciar_raw = 1'b0;
    chaves_raw  = 4'b0000;
    ciclos(10);

    // Two switches at once: 0110
    n7 = cnt_err;
    chaves_raw = 4'b0110;
    apos_bordas(7);
`ifdef ONEHOT_CHECK_EN
    check("onehot_err_e6", erro_jogada, 1'b1);
    check("onehot_no_pulse", jogada_pulso, 1'b0);
    check("onehot_jogada_kept", jogada, 4'b0001);
    check("onehot_db_solta", db_estado, 4'd3);
`else
    check("multi_pulse_e6", jogada_pulso, 1'b1);
    check("multi_jogada", jogada, 4'b0110);
    check("multi_err_low", erro_jogada, 1'b0);
`endif
    @(negedge clock);
    ciclos(5);
    chaves_raw = 4'b0000;
    ciclos(10);
`ifdef ONEHOT_CHECK_EN
    check("onehot_err_count", cnt_err - n7, 1);
`else
    check("multi_err_count", cnt_err - n7, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
